// File: rtl/btn_sched_pkg.sv
// ---------------------------------------------------------------------------
// btn_sched_pkg
// Shared types and sizing helpers for the button debounce scheduler.
//   sched_state_e : scan FSM states (SCAN, SETTLE, EMIT)
//   btn_evt_t     : event payload {id, pressed}
//   tick_cnt_w()  : width of the free-running debounce tick counter
//   idx_w()       : width of a button index
// ---------------------------------------------------------------------------
package btn_sched_pkg;

    localparam int EVT_ID_W = 4;   // wide enough for the largest supported N_BTN (16)
    localparam int TIMER_W  = 8;   // holds SETTLE_TICKS up to 255

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                pressed;
    } btn_evt_t;

    function automatic int tick_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync
// Parameterized-width 2-FF synchronizer. Both stages reset to all ones so an
// idle (released, active-low) button reads as released out of reset.
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   i_d   in  W  asynchronous inputs
//   o_q   out W  synchronized outputs
// ---------------------------------------------------------------------------
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {W{1'b1}};
            r_sync <= {W{1'b1}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce_sched.sv
// ---------------------------------------------------------------------------
// btn_debounce_sched
// Debounces N_BTN active-low buttons with one shared settle timer. A
// round-robin SCAN/SETTLE/EMIT FSM looks at one button per clock; a button
// whose synchronized level differs from its committed level must hold the new
// level for SETTLE_TICKS ticks before being committed. Commits are reported
// on a valid/ready event stream and presses are counted (wrapping).
// Build option: define BTN_RELEASE_EVT_EN to also report release events;
// otherwise only presses are reported and evt_pressed is constant 1.
// Ports:
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   btn_raw      in   N_BTN    raw button pins, active-low
//   btn_state    out  N_BTN    debounced levels, active-low
//   evt_valid    out  1        event available
//   evt_ready    in   1        consumer accepts event
//   evt_id       out  IDX_W    button index of the event
//   evt_pressed  out  1        1 = press, 0 = release
//   press_count  out  CNT_W    committed presses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module btn_debounce_sched
    import btn_sched_pkg::*;
#(
    parameter int  N_BTN        = 4,
    parameter int  TICK_DIV     = 4096,
    parameter int  SETTLE_TICKS = 15,
    parameter int  CNT_W        = 5,
    localparam int IDX_W        = idx_w(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_id,
    output logic             evt_pressed,
    output logic [CNT_W-1:0] press_count
);

    localparam int TW = tick_cnt_w(TICK_DIV);

`ifdef BTN_RELEASE_EVT_EN
    localparam logic PRESSED_RST = 1'b0;
`else
    // Only presses are ever reported, so the flag register holds 1 forever.
    localparam logic PRESSED_RST = 1'b1;
`endif

    logic [N_BTN-1:0]   w_sync;
    logic [TW-1:0]      r_tick_cnt;
    logic               w_tick;

    sched_state_e       r_state,     w_state_nxt;
    logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_adv;
    logic [TIMER_W-1:0] r_timer,     w_timer_nxt;
    logic               r_cand,      w_cand_nxt;
    logic [N_BTN-1:0]   r_btn_state, w_btn_state_nxt;
    logic [CNT_W-1:0]   r_press_cnt, w_press_cnt_nxt;
    logic               r_evt_valid, w_evt_valid_nxt;
    btn_evt_t           r_evt,       w_evt_nxt;
    logic               w_report;

    btn_sync #(.W(N_BTN)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (btn_raw),
        .o_q   (w_sync)
    );

    // Free-running tick counter; wraps naturally because TICK_DIV is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= {TW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Tick fires on the last count, i.e. TICK_DIV cycles after reset release.
    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_idx_adv = (r_idx == IDX_W'(N_BTN - 1)) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));

`ifdef BTN_RELEASE_EVT_EN
    assign w_report = 1'b1;
`else
    assign w_report = ~r_cand;   // candidate 0 means a press
`endif

    // Next-state and datapath update for the scan FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_timer_nxt     = r_timer;
        w_cand_nxt      = r_cand;
        w_btn_state_nxt = r_btn_state;
        w_press_cnt_nxt = r_press_cnt;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_nxt       = r_evt;
        case (r_state)
            SCAN: begin
                if (w_sync[r_idx] != r_btn_state[r_idx]) begin
                    w_cand_nxt  = w_sync[r_idx];
                    w_timer_nxt = TIMER_W'(SETTLE_TICKS);
                    w_state_nxt = SETTLE;
                end else begin
                    w_idx_nxt = w_idx_adv;
                end
            end
            SETTLE: begin
                // A bounce back to the old level wins over a same-cycle tick.
                if (w_sync[r_idx] != r_cand) begin
                    w_idx_nxt   = w_idx_adv;
                    w_state_nxt = SCAN;
                end else if (w_tick) begin
                    if (r_timer > TIMER_W'(1)) begin
                        w_timer_nxt = r_timer - TIMER_W'(1);
                    end else begin
                        w_btn_state_nxt[r_idx] = r_cand;
                        if (!r_cand) begin
                            w_press_cnt_nxt = r_press_cnt + CNT_W'(1);
                        end else begin
                            w_press_cnt_nxt = r_press_cnt;
                        end
                        if (w_report) begin
                            w_evt_valid_nxt   = 1'b1;
                            w_evt_nxt.id      = EVT_ID_W'(r_idx);
                            w_evt_nxt.pressed = ~r_cand;
                            w_state_nxt       = EMIT;
                        end else begin
                            w_idx_nxt   = w_idx_adv;
                            w_state_nxt = SCAN;
                        end
                    end
                end else begin
                    w_timer_nxt = r_timer;
                end
            end
            EMIT: begin
                if (r_evt_valid && evt_ready) begin
                    w_evt_valid_nxt = 1'b0;
                    w_idx_nxt       = w_idx_adv;
                    w_state_nxt     = SCAN;
                end else begin
                    w_evt_valid_nxt = r_evt_valid;
                end
            end
            default: begin
                w_evt_valid_nxt = 1'b0;
                w_state_nxt     = SCAN;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SCAN;
            r_idx         <= {IDX_W{1'b0}};
            r_timer       <= {TIMER_W{1'b0}};
            r_cand        <= 1'b1;
            r_btn_state   <= {N_BTN{1'b1}};
            r_press_cnt   <= {CNT_W{1'b0}};
            r_evt_valid   <= 1'b0;
            r_evt.id      <= {EVT_ID_W{1'b0}};
            r_evt.pressed <= PRESSED_RST;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_cand        <= w_cand_nxt;
            r_btn_state   <= w_btn_state_nxt;
            r_press_cnt   <= w_press_cnt_nxt;
            r_evt_valid   <= w_evt_valid_nxt;
            r_evt         <= w_evt_nxt;
        end
    end

    assign btn_state   = r_btn_state;
    assign evt_valid   = r_evt_valid;
    assign evt_id      = r_evt.id[IDX_W-1:0];
    assign evt_pressed = r_evt.pressed;
    assign press_count = r_press_cnt;

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Directed bench for btn_debounce_sched: N_BTN=4, TICK_DIV=4, SETTLE_TICKS=3.
module tb_btn_debounce_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_id;
    logic       evt_pressed;
    logic [4:0] press_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       pressed;
    } evt_rec_t;
    evt_rec_t evq[$];

`ifdef BTN_RELEASE_EVT_EN
    localparam logic EXP_P_RST = 1'b0;
`else
    localparam logic EXP_P_RST = 1'b1;
`endif

    btn_debounce_sched #(
        .N_BTN(4), .TICK_DIV(4), .SETTLE_TICKS(3), .CNT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_pressed(evt_pressed), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Record every completed handshake.
    always @(posedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            evq.push_back('{id: evt_id, pressed: evt_pressed});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        btn_raw = 4'hF;
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        evq.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_raw = 4'hF;
        @(negedge clk);
        checks++; if (btn_state !== 4'hF) begin errors++; $display("FAIL rst_btn_state got=%h exp=%h", btn_state, 4'hF); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL rst_evt_id got=%0d exp=0", evt_id); end
        checks++; if (evt_pressed !== EXP_P_RST) begin errors++; $display("FAIL rst_evt_pressed got=%b exp=%b", evt_pressed, EXP_P_RST); end
        checks++; if (press_count !== 5'd0) begin errors++; $display("FAIL rst_press_count got=%0d exp=0", press_count); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (evt_valid !== 1'b0 || btn_state !== 4'hF) begin errors++; $display("FAIL idle_after_reset valid=%b state=%h exp valid=0 state=f", evt_valid, btn_state); end
    endtask

    task automatic test_press();
        do_reset();
        btn_raw[2] = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL press_evt_count got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            checks++; if (evq[0].id !== 2'd2 || evq[0].pressed !== 1'b1) begin errors++; $display("FAIL press_evt got id=%0d p=%b exp id=2 p=1", evq[0].id, evq[0].pressed); end
        end
        checks++; if (btn_state !== 4'b1011) begin errors++; $display("FAIL press_btn_state got=%b exp=1011", btn_state); end
        checks++; if (press_count !== 5'd1) begin errors++; $display("FAIL press_count got=%0d exp=1", press_count); end
    endtask

    task automatic test_glitch();
        do_reset();
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (5) @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL glitch_evt_count got=%0d exp=0", evq.size()); end
        checks++; if (btn_state !== 4'hF) begin errors++; $display("FAIL glitch_btn_state got=%h exp=f", btn_state); end
        checks++; if (press_count !== 5'd0) begin errors++; $display("FAIL glitch_press_count got=%0d exp=0", press_count); end
        // Scanner must still be alive after the aborted settle.
        btn_raw[3] = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (evq.size() !== 1 || btn_state !== 4'b0111) begin errors++; $display("FAIL glitch_then_press events=%0d state=%b exp events=1 state=0111", evq.size(), btn_state); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        // Timed so the synchronized presses first appear while the scanner sits on index 0.
        repeat (2) @(negedge clk);
        btn_raw = 4'b0110;
        repeat (60) @(negedge clk);
        checks++; if (evq.size() !== 2) begin errors++; $display("FAIL simul_evt_count got=%0d exp=2", evq.size()); end
        if (evq.size() >= 2) begin
            checks++; if (evq[0].id !== 2'd0 || evq[0].pressed !== 1'b1) begin errors++; $display("FAIL simul_first got id=%0d p=%b exp id=0 p=1", evq[0].id, evq[0].pressed); end
            checks++; if (evq[1].id !== 2'd3 || evq[1].pressed !== 1'b1) begin errors++; $display("FAIL simul_second got id=%0d p=%b exp id=3 p=1", evq[1].id, evq[1].pressed); end
        end
        checks++; if (press_count !== 5'd2) begin errors++; $display("FAIL simul_press_count got=%0d exp=2", press_count); end
        checks++; if (btn_state !== 4'b0110) begin errors++; $display("FAIL simul_btn_state got=%b exp=0110", btn_state); end
    endtask

    task automatic test_back_to_back_stall();
        bit ok;
        int bad = 0;
        do_reset();
        evt_ready = 1'b0;
        btn_raw[1] = 1'b0;
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_pressed !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got=%0d bad cycles exp=0", bad); end
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL stall_no_handshake got=%0d exp=0", evq.size()); end
        evt_ready = 1'b1;
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_drop got=%b exp=0", evt_valid); end
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL stall_one_handshake got=%0d exp=1", evq.size()); end
        repeat (40) @(negedge clk);
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL stall_no_duplicate got=%0d exp=1", evq.size()); end
        checks++; if (press_count !== 5'd1) begin errors++; $display("FAIL stall_press_count got=%0d exp=1", press_count); end
    endtask

    task automatic test_release();
        do_reset();
        btn_raw[2] = 1'b0;
        repeat (40) @(negedge clk);
        evq.delete();
        btn_raw[2] = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (btn_state !== 4'hF) begin errors++; $display("FAIL release_btn_state got=%h exp=f", btn_state); end
        checks++; if (press_count !== 5'd1) begin errors++; $display("FAIL release_press_count got=%0d exp=1", press_count); end
`ifdef BTN_RELEASE_EVT_EN
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL release_evt_count got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            checks++; if (evq[0].id !== 2'd2 || evq[0].pressed !== 1'b0) begin errors++; $display("FAIL release_evt got id=%0d p=%b exp id=2 p=0", evq[0].id, evq[0].pressed); end
        end
`else
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL release_evt_count got=%0d exp=0", evq.size()); end
`endif
    endtask

    task automatic test_reset_abort();
        bit ok;
        // Mid-SETTLE: btn 0 enters SETTLE around cycle 5 and would commit around cycle 16.
        do_reset();
        btn_raw[0] = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (btn_state !== 4'hF) begin errors++; $display("FAIL settle_not_yet_committed got=%h exp=f", btn_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (btn_state !== 4'hF || evt_valid !== 1'b0 || press_count !== 5'd0) begin errors++; $display("FAIL settle_async_reset state=%h valid=%b cnt=%0d exp f/0/0", btn_state, evt_valid, press_count); end
        btn_raw = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (evq.size() !== 0 || btn_state !== 4'hF) begin errors++; $display("FAIL settle_aborted events=%0d state=%h exp 0/f", evq.size(), btn_state); end

        // Mid-EMIT: event pending with ready low, then reset drops it.
        do_reset();
        evt_ready = 1'b0;
        btn_raw[3] = 1'b0;
        wait_valid(40, ok);
        checks++; if (!ok || press_count !== 5'd1) begin errors++; $display("FAIL emit_pending ok=%b cnt=%0d exp 1/1", ok, press_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_pressed !== EXP_P_RST) begin errors++; $display("FAIL emit_async_reset_evt valid=%b id=%0d p=%b exp 0/0/%b", evt_valid, evt_id, evt_pressed, EXP_P_RST); end
        checks++; if (press_count !== 5'd0 || btn_state !== 4'hF) begin errors++; $display("FAIL emit_async_reset_state cnt=%0d state=%h exp 0/f", press_count, btn_state); end
        btn_raw = 4'hF;
        @(negedge clk);
        evt_ready = 1'b1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (evq.size() !== 0) begin errors++; $display("FAIL emit_dropped got=%0d exp=0", evq.size()); end
    endtask

    task automatic test_wrap();
        int exp_evts;
        do_reset();
        for (int i = 0; i < 33; i++) begin
            btn_raw[0] = 1'b0;
            repeat (25) @(negedge clk);
            btn_raw[0] = 1'b1;
            repeat (25) @(negedge clk);
        end
`ifdef BTN_RELEASE_EVT_EN
        exp_evts = 66;
`else
        exp_evts = 33;
`endif
        checks++; if (press_count !== 5'd1) begin errors++; $display("FAIL wrap_press_count got=%0d exp=1", press_count); end
        checks++; if (evq.size() !== exp_evts) begin errors++; $display("FAIL wrap_evt_count got=%0d exp=%0d", evq.size(), exp_evts); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_simultaneous();
        test_back_to_back_stall();
        test_release();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
